// File: rtl/bmem_arbiter_pkg.sv
// rtl/bmem_arbiter_pkg.sv - shared types for the cache-to-bmem arbiter
package bmem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  typedef enum logic {
    ICACHE,
    DCACHE
  } arb_owner_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              write;
    logic [LINE_W-1:0] wdata;
  } bmem_req_t;

endpackage

// File: rtl/bmem_arbiter_rr.sv
// rtl/bmem_arbiter_rr.sv - two-way round-robin grant from request bits and last grant
module bmem_arbiter_rr
  import bmem_arbiter_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  arb_owner_t last_grant,
  output logic       grant_valid,
  output arb_owner_t grant
);

  always_comb begin
    grant_valid = req_i | req_d;
    grant       = ICACHE;
    if (req_i && req_d) begin
      grant = (last_grant == ICACHE) ? DCACHE : ICACHE;
    end else if (req_d) begin
      grant = DCACHE;
    end
  end

endmodule

// File: rtl/bmem_arbiter.sv
// rtl/bmem_arbiter.sv - shares the single bmem line port between icache and dcache
module bmem_arbiter
  import bmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_W,
  parameter int LINE_WIDTH  = LINE_W,
  parameter int OFFSET_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_read,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic [ADDR_WIDTH-1:0] bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [LINE_WIDTH-1:0] bmem_wdata,
  input  logic [LINE_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_resp
);

  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
    ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

  arb_state_t state, state_next;
  arb_owner_t owner, last_grant, grant;
  logic       grant_valid;
  bmem_req_t  req;

  bmem_arbiter_rr u_rr (
    .req_i      (i_read),
    .req_d      (d_read | d_write),
    .last_grant (last_grant),
    .grant_valid(grant_valid),
    .grant      (grant)
  );

  always_comb begin
    state_next = state;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      IDLE: if (grant_valid) state_next = BUSY;
      BUSY: begin
        bmem_read  = req.read;
        bmem_write = req.write;
        bmem_addr  = req.addr;
        bmem_wdata = req.wdata;
        if (bmem_resp) state_next = RESP;
      end
      RESP: begin
        i_resp     = (owner == ICACHE);
        d_resp     = (owner == DCACHE);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A simultaneous read+write from the dcache is resolved as a writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= ICACHE;
      last_grant <= DCACHE;
      req        <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && grant_valid) begin
        owner      <= grant;
        last_grant <= grant;
        if (grant == ICACHE) begin
          req.addr  <= i_addr & ~OFFSET_MASK;
          req.read  <= 1'b1;
          req.write <= 1'b0;
          req.wdata <= '0;
        end else begin
          req.addr  <= d_addr & ~OFFSET_MASK;
          req.read  <= ~d_write;
          req.write <= d_write;
          req.wdata <= d_wdata;
        end
      end
      if (state == BUSY && bmem_resp && req.read) begin
        if (owner == ICACHE) i_rdata <= bmem_rdata;
        else                 d_rdata <= bmem_rdata;
      end
    end
  end

  a_no_read_and_write: assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));

endmodule
